// File: rtl/hilo_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_div_if
//  Description : Request/response bundle between the EX stage and the HI/LO
//                divider (operands and flush in, stall/ready/results out).
//  Revision    : 1.0 - initial release
// ============================================================================
interface hilo_div_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             annul_i;
    logic             busy_o;
    logic             ready_o;
    logic [WIDTH-1:0] lo_o;
    logic [WIDTH-1:0] hi_o;

    modport master (
        output start_i, signed_i, a_i, b_i, annul_i,
        input  busy_o, ready_o, lo_o, hi_o
    );

    modport slave (
        input  start_i, signed_i, a_i, b_i, annul_i,
        output busy_o, ready_o, lo_o, hi_o
    );
endinterface
`default_nettype wire

// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_div_unit
//  Description : Iterative radix-2 restoring divider for MIPS DIV/DIVU.
//                Quotient to LO, remainder to HI; stalls EX while iterating.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    hilo_div_if.slave   bus
);
    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DZERO = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;

    logic             w_accept;
    logic             w_busy;
    logic             w_ready;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_accept = (r_state == S_IDLE) && bus.start_i && !bus.annul_i;

    // Magnitudes are taken as unsigned, so |0x80000000| stays 0x80000000.
    assign w_abs_a = (bus.signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
    assign w_abs_b = (bus.signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

    // The remainder always fits WIDTH bits after the conditional subtract,
    // so a modulo-WIDTH subtraction yields the exact restored value.
    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_shift[WIDTH-1:0] - (w_ge ? r_dvs : '0);
    assign w_quo_next = {r_dvd[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_ready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (bus.b_i == '0) ? S_DZERO : S_RUN;
                end
            end
            S_DZERO: begin
                w_busy       = 1'b1;
                w_state_next = bus.annul_i ? S_IDLE : S_DONE;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (bus.annul_i) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == C_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_ready      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            if (w_accept) begin
                // A zero divisor keeps the raw dividend: it becomes HI as-is.
                r_dvd   <= (bus.b_i == '0) ? bus.a_i : w_abs_a;
                r_dvs   <= w_abs_b;
                r_rem   <= '0;
                r_cnt   <= '0;
                r_neg_q <= bus.signed_i && (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                r_neg_r <= bus.signed_i && bus.a_i[WIDTH-1];
            end else if (r_state == S_DZERO && !bus.annul_i) begin
                r_lo <= '1;
                r_hi <= r_dvd;
            end else if (r_state == S_RUN && !bus.annul_i) begin
                r_dvd <= w_quo_next;
                r_rem <= w_rem_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == C_LAST) begin
                    r_lo <= r_neg_q ? -w_quo_next : w_quo_next;
                    r_hi <= r_neg_r ? -w_rem_next : w_rem_next;
                end
            end
        end
    end

    assign bus.busy_o  = w_busy;
    assign bus.ready_o = w_ready;
    assign bus.lo_o    = r_lo;
    assign bus.hi_o    = r_hi;

endmodule
`default_nettype wire
